// File: rtl/sipo_frame_sync.sv
`default_nettype none
// ============================================================================
//  Module   : sipo_frame_sync
//  Purpose  : Frame synchroniser for the 8-bit SIPO window. While hunting it
//             compares every newly shifted window with SYNC_WORD (any bit
//             alignment). On a match it locks and slices each following
//             group of 8 serial bits into a payload byte, strobing
//             byte_valid for one cycle. After FRAME_LEN bytes it flags
//             frame_done, counts the frame and resumes hunting.
//  Ports    : clk        - system clock, rising edge
//             reset      - synchronous, active-high reset
//             shift_en   - window_in carries one newly shifted bit this cycle
//             window_in  - SIPO window, bit 0 newest, bit WIDTH-1 oldest
//             sync_lock  - high while a frame payload is being collected
//             sync_found - one-cycle pulse after the sync word is seen
//             byte_out   - last completed payload byte (held between strobes)
//             byte_valid - one-cycle strobe, byte_out/byte_idx are new
//             byte_idx   - position of byte_out within the frame
//             frame_done - one-cycle pulse with the last byte's strobe
//             frame_cnt  - completed frames since reset, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module sipo_frame_sync #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD = 8'hA5,
    parameter int               FRAME_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] window_in,
    output logic             sync_lock,
    output logic             sync_found,
    output logic [WIDTH-1:0] byte_out,
    output logic             byte_valid,
    output logic [7:0]       byte_idx,
    output logic             frame_done,
    output logic [15:0]      frame_cnt
);

    localparam logic [0:0] S_HUNT    = 1'b0;
    localparam logic [0:0] S_PAYLOAD = 1'b1;

    localparam logic [7:0]  c_last_byte = 8'(FRAME_LEN - 1);
    localparam logic [2:0]  c_last_bit  = 3'd7;
    localparam logic [15:0] c_cnt_max   = 16'hFFFF;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_byte_cnt;
    logic             r_sync_found;
    logic [WIDTH-1:0] r_byte_out;
    logic             r_byte_valid;
    logic [7:0]       r_byte_idx;
    logic             r_frame_done;
    logic [15:0]      r_frame_cnt;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [0:0]       w_state_nxt;
    logic [2:0]       w_bit_cnt_nxt;
    logic [7:0]       w_byte_cnt_nxt;
    logic             w_sync_found_nxt;
    logic [WIDTH-1:0] w_byte_out_nxt;
    logic             w_byte_valid_nxt;
    logic [7:0]       w_byte_idx_nxt;
    logic             w_frame_done_nxt;
    logic [15:0]      w_frame_cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_HUNT;
            r_bit_cnt    <= 3'd0;
            r_byte_cnt   <= 8'd0;
            r_sync_found <= 1'b0;
            r_byte_out   <= '0;
            r_byte_valid <= 1'b0;
            r_byte_idx   <= 8'd0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= 16'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_byte_cnt   <= w_byte_cnt_nxt;
            r_sync_found <= w_sync_found_nxt;
            r_byte_out   <= w_byte_out_nxt;
            r_byte_valid <= w_byte_valid_nxt;
            r_byte_idx   <= w_byte_idx_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
        end
    end

    // Pulses default to 0 every cycle, so stalled cycles clear them while
    // all other state holds.
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_byte_cnt_nxt   = r_byte_cnt;
        w_sync_found_nxt = 1'b0;
        w_byte_out_nxt   = r_byte_out;
        w_byte_valid_nxt = 1'b0;
        w_byte_idx_nxt   = r_byte_idx;
        w_frame_done_nxt = 1'b0;
        w_frame_cnt_nxt  = r_frame_cnt;

        if (shift_en) begin
            case (r_state)
                S_HUNT: begin
                    if (window_in == SYNC_WORD) begin
                        w_state_nxt      = S_PAYLOAD;
                        w_bit_cnt_nxt    = 3'd0;
                        w_byte_cnt_nxt   = 8'd0;
                        w_sync_found_nxt = 1'b1;
                    end
                end

                S_PAYLOAD: begin
                    // The sync word is deliberately not checked here: a
                    // payload byte equal to SYNC_WORD is ordinary data.
                    if (r_bit_cnt == c_last_bit) begin
                        // Eighth new bit: the whole window is one payload byte.
                        w_byte_out_nxt   = window_in;
                        w_byte_idx_nxt   = r_byte_cnt;
                        w_byte_valid_nxt = 1'b1;
                        w_bit_cnt_nxt    = 3'd0;
                        w_byte_cnt_nxt   = r_byte_cnt + 8'd1;
                        if (r_byte_cnt == c_last_byte) begin
                            w_frame_done_nxt = 1'b1;
                            w_state_nxt      = S_HUNT;
                            if (r_frame_cnt != c_cnt_max) begin
                                w_frame_cnt_nxt = r_frame_cnt + 16'd1;
                            end
                        end
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    end
                end

                default: begin
                    w_state_nxt = S_HUNT;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    assign sync_lock  = (r_state == S_PAYLOAD);
    assign sync_found = r_sync_found;
    assign byte_out   = r_byte_out;
    assign byte_valid = r_byte_valid;
    assign byte_idx   = r_byte_idx;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sipo_frame_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sipo_frame_sync
//  Purpose  : Self-checking bench for sipo_frame_sync. A bench-side SIPO
//             builds the window from a serial bit stream; a reference model
//             works on sample indices: after a sync at sample s, bytes are
//             the windows at samples s+8, s+16, ... s+8*FRAME_LEN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sipo_frame_sync;

    localparam int         c_frame_len = 4;
    localparam logic [7:0] c_sync      = 8'hA5;

    logic        clk;
    logic        reset;
    logic        shift_en;
    logic [7:0]  window_in;
    logic        sync_lock;
    logic        sync_found;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic [7:0]  byte_idx;
    logic        frame_done;
    logic [15:0] frame_cnt;

    sipo_frame_sync #(
        .WIDTH     (8),
        .SYNC_WORD (c_sync),
        .FRAME_LEN (c_frame_len)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .shift_en   (shift_en),
        .window_in  (window_in),
        .sync_lock  (sync_lock),
        .sync_found (sync_found),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_idx   (byte_idx),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Bench SIPO register
    logic [7:0] sipo;

    // Reference model state
    bit          m_hunting;
    int          m_n;       // sample index since reset
    int          m_start;   // sample index of the sync match
    logic        e_sync_found;
    logic [7:0]  e_byte_out;
    logic        e_byte_valid;
    logic [7:0]  e_byte_idx;
    logic        e_frame_done;
    logic [15:0] e_frame_cnt;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic en, input logic [7:0] win);
        int d;
        int k;
        e_sync_found = 1'b0;
        e_byte_valid = 1'b0;
        e_frame_done = 1'b0;
        if (rst) begin
            m_hunting   = 1'b1;
            m_n         = 0;
            m_start     = 0;
            e_byte_out  = 8'h00;
            e_byte_idx  = 8'h00;
            e_frame_cnt = 16'h0000;
        end else if (en) begin
            m_n++;
            if (m_hunting) begin
                if (win == c_sync) begin
                    m_hunting    = 1'b0;
                    m_start      = m_n;
                    e_sync_found = 1'b1;
                end
            end else begin
                d = m_n - m_start;
                if (d % 8 == 0) begin
                    k            = d / 8 - 1;
                    e_byte_out   = win;
                    e_byte_idx   = 8'(k);
                    e_byte_valid = 1'b1;
                    if (k == c_frame_len - 1) begin
                        e_frame_done = 1'b1;
                        m_hunting    = 1'b1;
                        if (e_frame_cnt != 16'hFFFF) e_frame_cnt = e_frame_cnt + 16'd1;
                    end
                end
            end
        end
    endtask

    // One clock: apply inputs, take the edge, update model, compare 1 ns later.
    task automatic do_cycle(input logic rst, input logic en, input logic [7:0] win);
        reset     = rst;
        shift_en  = en;
        window_in = win;
        @(posedge clk);
        model_edge(rst, en, win);
        #1;
        chk("sync_lock",  {15'd0, sync_lock},  {15'd0, ~m_hunting});
        chk("sync_found", {15'd0, sync_found}, {15'd0, e_sync_found});
        chk("byte_valid", {15'd0, byte_valid}, {15'd0, e_byte_valid});
        chk("byte_out",   {8'd0, byte_out},    {8'd0, e_byte_out});
        chk("byte_idx",   {8'd0, byte_idx},    {8'd0, e_byte_idx});
        chk("frame_done", {15'd0, frame_done}, {15'd0, e_frame_done});
        chk("frame_cnt",  frame_cnt,           e_frame_cnt);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            do_cycle(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
        end
        sipo = 8'h00;
    endtask

    // mode 0: no stalls, 1: stall before every bit, 2: random stalls
    task automatic send_bit(input logic b, input int mode);
        if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
            do_cycle(1'b0, 1'b0, 8'($urandom));
        end
        sipo = {sipo[6:0], b};
        do_cycle(1'b0, 1'b1, sipo);
    endtask

    task automatic send_byte(input logic [7:0] v, input int mode);
        for (int i = 7; i >= 0; i--) send_bit(v[i], mode);
    endtask

    task automatic send_frame(input int mode);
        send_byte(8'hA5, mode);
        send_byte(8'h3C, mode);
        send_byte(8'hFF, mode);
        send_byte(8'h00, mode);
        send_byte(8'h81, mode);
    endtask

    initial begin
        reset     = 1'b1;
        shift_en  = 1'b0;
        window_in = 8'h00;
        sipo      = 8'h00;
        m_hunting = 1'b1;
        m_n       = 0;
        m_start   = 0;
        e_sync_found = 1'b0;
        e_byte_out   = 8'h00;
        e_byte_valid = 1'b0;
        e_byte_idx   = 8'h00;
        e_frame_done = 1'b0;
        e_frame_cnt  = 16'h0000;

        // 1: reset, then a matching window locks one cycle later
        do_reset(2);
        do_cycle(1'b0, 1'b1, 8'hA5);
        chk("t1_sync_found", {15'd0, sync_found}, 16'd1);
        chk("t1_sync_lock",  {15'd0, sync_lock},  16'd1);

        // 2: full frame, shift every cycle
        do_reset(1);
        send_frame(0);
        chk("t2_frame_cnt", frame_cnt, 16'd1);
        chk("t2_byte_out",  {8'd0, byte_out}, 16'h0081);
        do_cycle(1'b0, 1'b1, {sipo[6:0], 1'b0});
        sipo = {sipo[6:0], 1'b0};
        chk("t2_lock_after", {15'd0, sync_lock}, 16'd0);

        // 3: same stream with a stall before every bit
        do_reset(1);
        send_frame(1);
        chk("t3_frame_cnt", frame_cnt, 16'd1);

        // 4: payload containing the sync word, then a never-locking pattern
        do_reset(1);
        send_byte(8'hA5, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h5A, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h42, 0);
        chk("t4_frame_cnt", frame_cnt, 16'd1);
        do_reset(1);
        for (int i = 0; i < 5; i++) send_byte(8'hAA, 0);
        chk("t4_alt_lock", {15'd0, sync_lock}, 16'd0);

        // 5: reset after payload byte 1, then a clean frame restarts at idx 0
        do_reset(1);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        send_byte(8'hFF, 0);
        do_reset(1);
        chk("t5_frame_cnt", frame_cnt, 16'd0);
        chk("t5_lock",      {15'd0, sync_lock}, 16'd0);
        send_frame(0);
        chk("t5_frame_cnt2", frame_cnt, 16'd1);

        // 6: two frames back-to-back
        do_reset(1);
        send_frame(0);
        send_frame(0);
        chk("t6_frame_cnt", frame_cnt, 16'd2);

        // Random: sync-rich byte stream, random stalls, rare resets
        do_reset(1);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1);
            if ($urandom_range(0, 3) == 0) send_byte(8'hA5, 2);
            else                           send_byte(8'($urandom), 2);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sipo_frame_sync.md
Name: sipo_frame_sync

Overview:
- Downstream consumer of the 8-bit serial-in/parallel-out shift register.
- Watches the sliding 8-bit window that register produces, hunts for a sync word, then slices the following serial bits into byte-aligned payload bytes with a one-cycle valid strobe.
- After a fixed-length frame it returns to hunting.
- Sits between the bit-level SIPO stage and byte-oriented logic, e.g. a FIFO or packet parser.

Parameters:
- WIDTH, 8, window/byte width. Only 8 is supported and verified.
- SYNC_WORD, 8'hA5, window pattern that starts a frame.
- FRAME_LEN, 4, payload bytes per frame, range 1..255.

Ports:
- clk  input  1  system clock; everything updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- shift_en  input  1  high on cycles where window_in holds one newly shifted bit; tie high when the SIPO shifts every cycle.
- window_in  input  WIDTH  parallel output of the SIPO. Bit 0 is the newest bit, bit WIDTH-1 the oldest (MSB-first serial order).
- sync_lock  output  1  level; high while in PAYLOAD state.
- sync_found  output  1  one-cycle pulse when the sync word is detected.
- byte_out  output  WIDTH  last completed payload byte; holds its value between strobes.
- byte_valid  output  1  one-cycle strobe; byte_out is new this cycle.
- byte_idx  output  8  index of the byte on byte_out, 0..FRAME_LEN-1.
- frame_done  output  1  one-cycle pulse, coincident with byte_valid of the last byte.
- frame_cnt  output  16  completed frames since reset; saturates at 16'hFFFF.

Behaviour:
- Reset (sampled on clk edge): state=HUNT, bit_cnt=0, byte_cnt=0. All outputs 0, including byte_out, byte_idx and frame_cnt. Reset mid-frame abandons the frame with no frame_done and no partial byte.
- A sample is an edge where shift_en=1. Edges with shift_en=0 change nothing except that all pulses clear to 0.
- HUNT state:
  - On a sample with window_in==SYNC_WORD: go to PAYLOAD, clear bit_cnt and byte_cnt, and assert sync_found for the following cycle.
  - Non-matching samples stay in HUNT.
  - Detection is sliding: any bit alignment matches.
- PAYLOAD state:
  - Each sample increments bit_cnt (0..7).
  - On the sample where bit_cnt==7 (8th new bit after sync or after the previous byte):
    - byte_out<=window_in, byte_idx<=byte_cnt, byte_valid=1 for one cycle;
    - bit_cnt<=0, byte_cnt<=byte_cnt+1.
  - If that byte has byte_cnt==FRAME_LEN-1, the same edge also:
    - asserts frame_done for one cycle;
    - increments frame_cnt (saturating);
    - returns state to HUNT.
  - The sync word is not re-checked inside PAYLOAD; payload bytes equal to SYNC_WORD are data.
- Back-to-back frames: hunting resumes on the first sample after frame_done. The window then still holds 7 old payload bits, so a match may straddle the payload tail. This is accepted behaviour.
- Latency:
  - byte_valid is high in the cycle immediately after the edge that sampled the byte's 8th bit.
  - sync_found is high in the cycle after the matching sample.
- sync_lock goes 1 on the edge entering PAYLOAD and 0 on the edge returning to HUNT.
- All outputs are registered; no combinational path from inputs to outputs.
- bit_cnt is 3 bits and byte_cnt 8 bits; both wrap only via the explicit clears above.

Test Plan:
1. Reset sequence: reset=1 for 2 cycles with random window_in/shift_en -> all outputs 0, state HUNT. Then feed window 8'hA5 with shift_en=1 -> sync_found=1 one cycle later, sync_lock=1.
2. Full frame, shift_en tied 1, driven through a real SIPO: serial bits 10100101, then payload 0x3C, 0xFF, 0x00, 0x81 MSB-first ->
   - 4 byte_valid strobes 8 cycles apart, values 3C, FF, 00, 81, byte_idx 0..3;
   - frame_done with the 0x81 strobe;
   - frame_cnt=1; sync_lock=0 afterwards.
3. Stalls: same stream with shift_en low on every other cycle -> identical byte sequence, with strobes 16 cycles apart. No outputs change during stalled cycles.
4. Payload contains 0xA5 -> emitted as data, no extra sync_found, frame still ends after 4 bytes. Alternating 10101010 pattern with no A5 -> never locks.
5. reset asserted after payload byte 1 -> next cycle all outputs 0 and frame_cnt unchanged at its cleared value 0. A fresh sync then restarts at byte_idx 0.
6. Two frames back-to-back with a sync immediately after the first frame_done -> second sync_found 8 samples after frame_done, frame_cnt=2.
